// File: rtl/spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx
//  Description : SPI receiver. Deserialises the 3-wire stream produced by
//                spi_tx (serial data, data clock, active-low select) into
//                parallel words. Frames are MSB first, and bits are sampled on
//                the rising edge of the data clock. All serial inputs are
//                asynchronous to clk_in and are synchronised internally.
//
//  Parameters  : DATA_WIDTH   bits per frame and width of data_out (>= 2)
//                SYNC_STAGES  depth of each input synchroniser (2..4)
//
//  Ports       : clk_in        in   system clock
//                rst_in        in   asynchronous reset, active-low
//                data_in       in   serial data
//                data_clk_in   in   serial data clock
//                sel_in        in   frame select, active-low
//                data_out      out  last complete received word
//                new_data_out  out  1-cycle pulse, data_out just updated
//                error_out     out  1-cycle pulse, frame aborted or over-length
//
//  Revision    : 1.0  initial release
// ============================================================================
module spi_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  data_in,
    input  logic                  data_clk_in,
    input  logic                  sel_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  new_data_out,
    output logic                  error_out
);

    localparam int c_cnt_w = $clog2(DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RECEIVE    = 2'd1,
        ST_WAIT_DESEL = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_sel_sync;
    logic                   r_clk_d;
    logic                   r_sel_d;
    // Walking-one marker: its top bit is set once every synchroniser stage
    // and the delayed copies hold genuine samples rather than reset values.
    logic [SYNC_STAGES:0]   r_flush;

    logic w_s_dat;
    logic w_s_clk;
    logic w_s_sel;
    logic w_flushed;

    assign w_s_dat   = r_dat_sync[SYNC_STAGES-1];
    assign w_s_clk   = r_clk_sync[SYNC_STAGES-1];
    assign w_s_sel   = r_sel_sync[SYNC_STAGES-1];
    assign w_flushed = r_flush[SYNC_STAGES];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_dat_sync <= '0;
            r_clk_sync <= '0;
            r_sel_sync <= '1;
            r_clk_d    <= 1'b0;
            r_sel_d    <= 1'b1;
            r_flush    <= '0;
        end else begin
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], data_in};
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], data_clk_in};
            r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], sel_in};
            r_clk_d    <= w_s_clk;
            r_sel_d    <= w_s_sel;
            r_flush    <= {r_flush[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // The sel chain resets to 1. If reset is released while the transmitter
    // still holds select low, the chain would show a false falling edge as
    // it refills. Frame starts are therefore only accepted once select has
    // been observed high on genuine samples, so a frame interrupted by reset
    // is ignored until a fresh select falling edge.
    logic r_armed;
    logic w_armed_next;

    assign w_armed_next = r_armed | (w_flushed & w_s_sel);

    logic w_clk_rise;
    logic w_sel_fall;
    logic w_sel_rise;

    assign w_clk_rise = w_s_clk & ~r_clk_d;
    assign w_sel_fall = ~w_s_sel & r_sel_d & r_armed;
    assign w_sel_rise = w_s_sel & ~r_sel_d;

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DATA_WIDTH-2:0] r_shift;
    logic                  r_overrun;

    state_t                w_state_next;
    logic [c_cnt_w-1:0]    w_cnt_next;
    logic [DATA_WIDTH-2:0] w_shift_next;
    logic                  w_overrun_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_new_next;
    logic                  w_err_next;

    // The shift register only needs DATA_WIDTH-1 bits: on the final rise the
    // word is assembled from it plus the bit currently on the data line.
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = {r_shift, w_s_dat};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_overrun    <= 1'b0;
            r_armed      <= 1'b0;
            data_out     <= '0;
            new_data_out <= 1'b0;
            error_out    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_shift      <= w_shift_next;
            r_overrun    <= w_overrun_next;
            r_armed      <= w_armed_next;
            data_out     <= w_data_next;
            new_data_out <= w_new_next;
            error_out    <= w_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_shift_next   = r_shift;
        w_overrun_next = r_overrun;
        w_data_next    = data_out;
        w_new_next     = 1'b0;
        w_err_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_sel_fall) begin
                    w_cnt_next     = '0;
                    w_overrun_next = 1'b0;
                    w_state_next   = ST_RECEIVE;
                end
            end

            ST_RECEIVE: begin
                // Select rising takes priority: a data clock edge arriving in
                // the same cycle belongs to no frame and is not sampled.
                if (w_sel_rise) begin
                    w_err_next   = (r_cnt != '0);
                    w_state_next = ST_IDLE;
                end else if (w_clk_rise) begin
                    w_shift_next = w_shifted[DATA_WIDTH-2:0];
                    w_cnt_next   = (r_cnt == c_cnt_full) ? r_cnt : r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        w_data_next  = w_shifted;
                        w_new_next   = 1'b1;
                        w_state_next = ST_WAIT_DESEL;
                    end
                end
            end

            ST_WAIT_DESEL: begin
                if (w_sel_rise) begin
                    w_err_next   = r_overrun;
                    w_state_next = ST_IDLE;
                end else if (w_clk_rise) begin
                    w_overrun_next = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
